// File: rtl/ml_ahb_resp_mux_master_1.sv
// AHB data-phase response mux for master 1 with embedded default slave.
// The decoder's address-phase select is captured while HREADY is high, and the
// selected slave's HRDATA/HREADY/HRESP are routed back in the data phase.
// Unmapped NONSEQ/SEQ accesses receive a two-cycle ERROR from the default slave.
// Completed default-slave errors are counted in a saturating debug counter.
`timescale 1ns/1ps

// Per-slave lane: passes the slave's response fields only when that slave owns
// the data phase, so the lanes can simply be OR-combined.
module ml_ahb_resp_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] s_hrdata,
  input  logic                  s_hready,
  input  logic [1:0]            s_hresp,
  output logic [DATA_WIDTH-1:0] l_hrdata,
  output logic                  l_hready,
  output logic [1:0]            l_hresp
);
  // Gate every field with the lane select.
  always_comb begin
    l_hrdata = sel ? s_hrdata : '0;
    l_hready = sel & s_hready;
    l_hresp  = sel ? s_hresp : 2'b00;
  end
endmodule

module ml_ahb_resp_mux_master_1 #(
  parameter int NUM_SLAVES    = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                             hclk,
  input  logic                             hresetn,
  input  logic [NUM_SLAVES-1:0]            hsel,
  input  logic                             hsel_default,
  input  logic [1:0]                       htrans,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hrdata,
  input  logic [NUM_SLAVES-1:0]            s_hready,
  input  logic [2*NUM_SLAVES-1:0]          s_hresp,
  output logic [DATA_WIDTH-1:0]            hrdata,
  output logic                             hready,
  output logic [1:0]                       hresp,
  input  logic                             err_clr,
  output logic [ERR_CNT_WIDTH-1:0]         err_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} dflt_state_t;

  dflt_state_t state, state_nxt;

  logic [NUM_SLAVES-1:0] sel_slave;   // data-phase owner among the real slaves
  logic                  sel_def;     // data-phase owner is the default slave
  logic [NUM_SLAVES-1:0] sel_low;     // lowest set bit of hsel
  logic                  any_hsel;
  logic                  xfer_active; // NONSEQ or SEQ
  logic                  dflt_go;     // qualifying default access sampled this edge
  logic                  dflt_ready;
  logic [1:0]            dflt_resp;

  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] lane_rdata;
  logic [NUM_SLAVES-1:0]                 lane_ready;
  logic [NUM_SLAVES-1:0][1:0]            lane_resp;
  logic [DATA_WIDTH-1:0]                 mux_rdata;
  logic                                  mux_ready;
  logic [1:0]                            mux_resp;

  // Overlapping selects resolve to the lowest index; scanning downward lets the
  // lowest set bit be the last assignment.
  always_comb begin
    sel_low = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hsel[i]) begin
        sel_low    = '0;
        sel_low[i] = 1'b1;
      end
    end
  end

  assign any_hsel    = |hsel;
  assign xfer_active = (htrans == 2'b10) || (htrans == 2'b11);
  assign dflt_go     = hready & hsel_default & ~any_hsel & xfer_active;

  // Address-phase capture; held through wait states.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      sel_slave <= '0;
      sel_def   <= 1'b0;
    end else if (hready) begin
      sel_slave <= sel_low;
      sel_def   <= ~any_hsel & hsel_default;
    end
  end

  // Default-slave state register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Default-slave next state and response: ERR1 stalls, ERR2 completes the ERROR.
  always_comb begin
    state_nxt  = state;
    dflt_ready = 1'b1;
    dflt_resp  = 2'b00;
    case (state)
      ST_IDLE: if (dflt_go) state_nxt = ST_ERR1;
      ST_ERR1: begin
        dflt_ready = 1'b0;
        dflt_resp  = 2'b01;
        state_nxt  = ST_ERR2;
      end
      ST_ERR2: begin
        dflt_resp = 2'b01;
        state_nxt = dflt_go ? ST_ERR1 : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // One masking lane per real slave.
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_lane
    ml_ahb_resp_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .sel      (sel_slave[g]),
      .s_hrdata (s_hrdata[g*DATA_WIDTH +: DATA_WIDTH]),
      .s_hready (s_hready[g]),
      .s_hresp  (s_hresp[2*g +: 2]),
      .l_hrdata (lane_rdata[g]),
      .l_hready (lane_ready[g]),
      .l_hresp  (lane_resp[g])
    );
  end

  // OR-combine the masked lanes; at most one is selected.
  always_comb begin
    mux_rdata = '0;
    mux_resp  = 2'b00;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      mux_rdata = mux_rdata | lane_rdata[i];
      mux_resp  = mux_resp  | lane_resp[i];
    end
    mux_ready = |lane_ready;
  end

  // Final response: default slave, a real slave, or an idle OKAY.
  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = 2'b00;
    if (sel_def) begin
      hready = dflt_ready;
      hresp  = dflt_resp;
    end else if (|sel_slave) begin
      hrdata = mux_rdata;
      hready = mux_ready;
      hresp  = mux_resp;
    end
  end

  // Count completed default-slave errors; clear wins over increment.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)                           err_count <= '0;
    else if (err_clr)                       err_count <= '0;
    else if (state == ST_ERR2 && !(&err_count)) err_count <= err_count + 1'b1;
  end

endmodule

// File: doc/ml_ahb_resp_mux_master_1.md
Name: ml_ahb_resp_mux_master_1

Overview:
Data-phase response stage downstream of the master 1 address decoder. It registers the decoder's one-hot slave select during the address phase and routes the selected slave's HRDATA/HREADY/HRESP back to master 1 in the following data phase. It embeds the default slave, which returns a two-cycle AHB ERROR for unmapped accesses. It also keeps a saturating count of default-slave errors for debug.

Parameters:
NUM_SLAVES, 2, number of real slaves reachable by master 1 (width of hsel).
DATA_WIDTH, 32, width of HRDATA.
ERR_CNT_WIDTH, 8, width of the default-slave error counter.

Ports:
hclk  input  1  AHB clock; all state updates on rising edge.
hresetn  input  1  asynchronous active-low reset.
hsel  input  NUM_SLAVES  one-hot slave select from the decoder (address phase).
hsel_default  input  1  default-slave select from the decoder (address phase).
htrans  input  2  master 1 HTRANS (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
s_hrdata  input  NUM_SLAVES*DATA_WIDTH  slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
s_hready  input  NUM_SLAVES  slave HREADYOUT.
s_hresp  input  2*NUM_SLAVES  slave HRESP; slave i occupies bits [2i +: 2].
hrdata  output  DATA_WIDTH  read data to master 1.
hready  output  1  HREADY to master 1; also drives every slave's HREADY input.
hresp  output  2  HRESP to master 1 (00 OKAY, 01 ERROR).
err_clr  input  1  synchronous clear of err_count.
err_count  output  ERR_CNT_WIDTH  number of completed default-slave ERROR responses, saturating.

Behaviour:
- Reset (hresetn=0, asynchronous):
  - data_sel cleared (no slave owns the data phase); FSM in IDLE; err_count=0.
  - Outputs during and after reset: hready=1, hresp=00, hrdata=0.
- Address-phase sampling:
  - The select is sampled only on edges where the output hready=1.
  - data_sel <= one-hot of the lowest-indexed set bit of hsel, else hsel_default, else none.
  - If more than one hsel bit is set, the lowest index wins. No error is raised for this.
  - When hready=0, data_sel holds its value.
- Output mux (combinational from data_sel and the default-slave FSM):
  - data_sel=slave i: hrdata, hready and hresp come from slave i's fields of s_hrdata/s_hready/s_hresp.
  - data_sel=none: hready=1, hresp=00, hrdata=0.
  - data_sel=default: hrdata=0; hready and hresp come from the FSM below.
- Default slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: hready=1, hresp=00.
  - IDLE -> ERR1 on an hready=1 edge with hsel_default=1, no hsel bit set, and htrans in {NONSEQ, SEQ}.
  - Default-selected IDLE or BUSY transfers get a zero-wait OKAY and the FSM stays in IDLE.
  - ERR1: hready=0, hresp=01; always -> ERR2.
  - ERR2: hready=1, hresp=01; err_count increments on this edge.
  - ERR2 -> ERR1 if a new qualifying default access is sampled on the same edge (back-to-back errors); otherwise ERR2 -> IDLE.
  - ERR2 -> IDLE also when the next transfer targets a real slave; data_sel then switches to that slave.
- err_count:
  - Saturates at all-ones.
  - err_clr has priority over an increment on the same edge (result 0).
- Latency:
  - Response appears one cycle after the address phase.
  - Wait states are inserted only by the selected slave or by the default-slave ERR1 state.
- Reset mid-transfer (including in ERR1/ERR2) returns to the reset values immediately. No response is completed and err_count is cleared.

Test Plan:
- Reset then idle: hresetn low for 3 cycles, htrans=00 -> hready=1, hresp=00, hrdata=0, err_count=0 throughout.
- Slave 0 read:
  - Stimulus: hsel=01, htrans=10; slave 0 drives s_hready 0 for 2 cycles then 1, s_hresp=00, data 0xCAFE_0001.
  - Required: hready mirrors that pattern one cycle after the address phase; hrdata=0xCAFE_0001 on the completing cycle; the next address is not sampled while hready=0.
- Unmapped NONSEQ:
  - Stimulus: hsel=00, hsel_default=1, htrans=10.
  - Required: next cycle hready=0/hresp=01, then hready=1/hresp=01, err_count=1.
- Back-to-back errors:
  - Stimulus: two default NONSEQ accesses, the second presented during ERR2.
  - Required: sequence ERR1, ERR2, ERR1, ERR2 with no intervening OKAY cycle; err_count=2.
- Default IDLE and overlap:
  - Default with htrans=00 -> one cycle of hready=1, hresp=00, err_count unchanged.
  - hsel=11 -> slave 0's response is routed.
- Saturation, clear and reset:
  - With ERR_CNT_WIDTH=2, 5 errors -> err_count=3.
  - err_clr asserted together with an ERR2 edge -> err_count=0.
  - Reset asserted while in ERR1 -> hready=1 immediately.
